// File: rtl/vend_transaction_ctrl_if.sv
// Purpose : bundles the coin acceptor, selector, dispenser and change hopper
//           signals of the vending transaction controller.
// Ports   : controller inputs  - in[1:0], coin_valid, sel, sel_valid, cancel,
//                                restock, vend_ack, change_ack
//           controller outputs - coin_ready, coin_reject, sold_out, short_credit,
//                                vend_req, vend_id, change_req, change_coin[1:0],
//                                credit[5:0], stock_a[3:0], stock_b[3:0]
// Handshake: vend_req/change_req are raised by the controller and held until the
//           matching 1-cycle ack pulse; the ack is consumed on the clock edge where
//           it is sampled high, and the request drops on that same edge unless
//           more coins of change are still owed.
interface vend_transaction_ctrl_if;
  logic [1:0] in;
  logic       coin_valid;
  logic       sel;
  logic       sel_valid;
  logic       cancel;
  logic       restock;
  logic       vend_ack;
  logic       change_ack;
  logic       coin_ready;
  logic       coin_reject;
  logic       sold_out;
  logic       short_credit;
  logic       vend_req;
  logic       vend_id;
  logic       change_req;
  logic [1:0] change_coin;
  logic [5:0] credit;
  logic [3:0] stock_a;
  logic [3:0] stock_b;

  // Controller side
  modport slave (
    input  in, coin_valid, sel, sel_valid, cancel, restock, vend_ack, change_ack,
    output coin_ready, coin_reject, sold_out, short_credit, vend_req, vend_id,
           change_req, change_coin, credit, stock_a, stock_b
  );

  // Environment side (coin acceptor, selector, dispenser, hopper)
  modport master (
    output in, coin_valid, sel, sel_valid, cancel, restock, vend_ack, change_ack,
    input  coin_ready, coin_reject, sold_out, short_credit, vend_req, vend_id,
           change_req, change_coin, credit, stock_a, stock_b
  );
endinterface

// File: rtl/vend_transaction_ctrl.sv
// Purpose : transaction controller for a two-product vending machine. Accumulates
//           credit in 5 rs steps, checks price and stock, then sequences the
//           dispense and the coin-by-coin change return. Tracks inventory.
// Ports   : clk       - clock, rising edge
//           reset     - asynchronous, active-low reset
//           bus       - vend_transaction_ctrl_if.slave (all handshake/status signals)
//           dbg_state - current FSM state (0 IDLE, 1 COLLECT, 2 VEND, 3 CHANGE)
module vend_transaction_ctrl #(
  parameter int PRICE_A    = 20,
  parameter int PRICE_B    = 15,
  parameter int STOCK_INIT = 8,
  parameter int CREDIT_MAX = 35,
  parameter int TIMEOUT    = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  vend_transaction_ctrl_if.slave bus,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VEND    = 2'd2,
    S_CHANGE  = 2'd3
  } state_t;

  localparam int          TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
  localparam logic [6:0]  CMAX      = 7'(CREDIT_MAX);
  localparam logic [5:0]  PA        = 6'(PRICE_A);
  localparam logic [5:0]  PB        = 6'(PRICE_B);
  localparam logic [3:0]  SINIT     = 4'(STOCK_INIT);

  state_t        state_q, state_d;
  logic [5:0]    credit_q, credit_d;
  logic [3:0]    stock_a_q, stock_a_d;
  logic [3:0]    stock_b_q, stock_b_d;
  logic          vend_id_q, vend_id_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          reject_q, reject_d;
  logic          sold_out_q, sold_out_d;
  logic          short_q, short_d;

  logic [3:0] coin_val;
  logic [6:0] credit_sum;
  logic       coin_ok;
  logic [5:0] sel_price;
  logic [3:0] sel_stock;
  logic [5:0] chg_val;
  logic       in_vend;
  logic       in_change;

  // Code 00 with a strobe carries no coin and is refused like code 11.
  always_comb begin
    coin_val = 4'd0;
    case (bus.in)
      2'b01:   coin_val = 4'd5;
      2'b10:   coin_val = 4'd10;
      default: coin_val = 4'd0;
    endcase
  end

  // 7-bit sum so a coin on top of a full 63 rs credit cannot wrap.
  assign credit_sum = {1'b0, credit_q} + {3'b000, coin_val};
  assign coin_ok    = (coin_val != 4'd0) && (credit_sum <= CMAX);
  assign sel_price  = bus.sel ? PB : PA;
  assign sel_stock  = bus.sel ? stock_b_q : stock_a_q;
  assign chg_val    = (credit_q >= 6'd10) ? 6'd10 : 6'd5;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      credit_q   <= 6'd0;
      stock_a_q  <= SINIT;
      stock_b_q  <= SINIT;
      vend_id_q  <= 1'b0;
      tmr_q      <= '0;
      reject_q   <= 1'b0;
      sold_out_q <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      stock_a_q  <= stock_a_d;
      stock_b_q  <= stock_b_d;
      vend_id_q  <= vend_id_d;
      tmr_q      <= tmr_d;
      reject_q   <= reject_d;
      sold_out_q <= sold_out_d;
      short_q    <= short_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    stock_a_d  = stock_a_q;
    stock_b_d  = stock_b_q;
    vend_id_d  = vend_id_q;
    tmr_d      = tmr_q;
    reject_d   = 1'b0;
    sold_out_d = 1'b0;
    short_d    = 1'b0;

    if (bus.coin_valid || bus.sel_valid) tmr_d = '0;

    case (state_q)
      S_IDLE, S_COLLECT: begin
        if ((state_q == S_IDLE) && bus.restock) begin
          stock_a_d = SINIT;
          stock_b_d = SINIT;
        end
        // cancel > coin > selection; a coin lost to cancel is refused.
        if (bus.cancel) begin
          reject_d = bus.coin_valid;
          if (state_q == S_COLLECT) state_d = S_CHANGE;
        end else if (bus.coin_valid) begin
          if (coin_ok) begin
            credit_d = credit_sum[5:0];
            if (state_q == S_IDLE) begin
              state_d = S_COLLECT;
              tmr_d   = '0;
            end
          end else begin
            reject_d = 1'b1;
          end
        end else if (bus.sel_valid) begin
          if (state_q == S_COLLECT) begin
            if (sel_stock == 4'd0) begin
              sold_out_d = 1'b1;
            end else if (credit_q < sel_price) begin
              short_d = 1'b1;
            end else begin
              credit_d  = credit_q - sel_price;
              vend_id_d = bus.sel;
              state_d   = S_VEND;
            end
          end
        end else if (state_q == S_COLLECT) begin
          if (tmr_q == TMR_LAST) state_d = S_CHANGE;
          else                   tmr_d = tmr_q + 1'b1;
        end
      end

      S_VEND: begin
        reject_d = bus.coin_valid;
        if (bus.vend_ack) begin
          if (vend_id_q) stock_b_d = stock_b_q - 4'd1;
          else           stock_a_d = stock_a_q - 4'd1;
          state_d = (credit_q != 6'd0) ? S_CHANGE : S_IDLE;
        end
      end

      S_CHANGE: begin
        reject_d = bus.coin_valid;
        if (bus.change_ack) begin
          credit_d = credit_q - chg_val;
          if (credit_q == chg_val) state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign in_vend   = (state_q == S_VEND);
  assign in_change = (state_q == S_CHANGE);

  assign bus.coin_ready   = (state_q == S_IDLE) || (state_q == S_COLLECT);
  assign bus.coin_reject  = reject_q;
  assign bus.sold_out     = sold_out_q;
  assign bus.short_credit = short_q;
  assign bus.vend_req     = in_vend;
  assign bus.vend_id      = in_vend & vend_id_q;
  assign bus.change_req   = in_change;
  // Coin choice follows the registered credit, so it updates the cycle after an ack.
  assign bus.change_coin  = !in_change ? 2'b00 :
                            (credit_q >= 6'd10) ? 2'b10 : 2'b01;
  assign bus.credit       = credit_q;
  assign bus.stock_a      = stock_a_q;
  assign bus.stock_b      = stock_b_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_vend_transaction_ctrl.sv
module tb_vend_transaction_ctrl;
  localparam int PRICE_A    = 20;
  localparam int PRICE_B    = 15;
  localparam int STOCK_INIT = 8;
  localparam int CREDIT_MAX = 35;
  localparam int TIMEOUT    = 40;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  vend_transaction_ctrl_if bus ();

  vend_transaction_ctrl #(
    .PRICE_A   (PRICE_A),
    .PRICE_B   (PRICE_B),
    .STOCK_INIT(STOCK_INIT),
    .CREDIT_MAX(CREDIT_MAX),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: a machine that is either dispensing, paying change,
  // or taking money (idle when it holds no credit)
  int m_credit;
  int m_stock[2];
  bit m_vend;
  bit m_change;
  int m_vid;
  int m_quiet;
  bit m_rej, m_so, m_sc;

  int n_vec;
  int n_err;

  task automatic model_reset();
    m_credit = 0;
    m_stock[0] = STOCK_INIT;
    m_stock[1] = STOCK_INIT;
    m_vend = 0;
    m_change = 0;
    m_vid = 0;
    m_quiet = 0;
    m_rej = 0;
    m_so = 0;
    m_sc = 0;
  endtask

  task automatic model_step(input int c, input int cv, input int sl, input int sv,
                            input int can, input int rs, input int va, input int ca);
    int val;
    int price;
    bit collecting;
    m_rej = 0;
    m_so = 0;
    m_sc = 0;
    if (m_vend) begin
      if (cv != 0) m_rej = 1;
      if (va != 0) begin
        m_stock[m_vid] = m_stock[m_vid] - 1;
        m_vend = 0;
        m_change = (m_credit > 0);
      end
    end else if (m_change) begin
      if (cv != 0) m_rej = 1;
      if (ca != 0) begin
        m_credit = m_credit - ((m_credit >= 10) ? 10 : 5);
        if (m_credit == 0) m_change = 0;
      end
    end else begin
      collecting = (m_credit > 0);
      if (!collecting && rs != 0) begin
        m_stock[0] = STOCK_INIT;
        m_stock[1] = STOCK_INIT;
      end
      if (can != 0) begin
        if (cv != 0) m_rej = 1;
        if (collecting) m_change = 1;
      end else if (cv != 0) begin
        val = (c == 1) ? 5 : (c == 2) ? 10 : 0;
        m_quiet = 0;
        if (val == 0 || m_credit + val > CREDIT_MAX) m_rej = 1;
        else m_credit = m_credit + val;
      end else if (sv != 0) begin
        m_quiet = 0;
        if (collecting) begin
          price = (sl != 0) ? PRICE_B : PRICE_A;
          if (m_stock[sl] == 0) m_so = 1;
          else if (m_credit < price) m_sc = 1;
          else begin
            m_credit = m_credit - price;
            m_vid = sl;
            m_vend = 1;
          end
        end
      end else if (collecting) begin
        m_quiet = m_quiet + 1;
        if (m_quiet >= TIMEOUT) m_change = 1;
      end
    end
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("coin_ready",   32'(bus.coin_ready),   32'(!m_vend && !m_change));
    chk("coin_reject",  32'(bus.coin_reject),  32'(m_rej));
    chk("sold_out",     32'(bus.sold_out),     32'(m_so));
    chk("short_credit", 32'(bus.short_credit), 32'(m_sc));
    chk("vend_req",     32'(bus.vend_req),     32'(m_vend));
    chk("vend_id",      32'(bus.vend_id),      32'(m_vend ? m_vid : 0));
    chk("change_req",   32'(bus.change_req),   32'(m_change));
    chk("change_coin",  32'(bus.change_coin),  32'(!m_change ? 0 : (m_credit >= 10) ? 2 : 1));
    chk("credit",       32'(bus.credit),       32'(m_credit));
    chk("stock_a",      32'(bus.stock_a),      32'(m_stock[0]));
    chk("stock_b",      32'(bus.stock_b),      32'(m_stock[1]));
  endtask

  // driver tasks: inputs change #1 after the edge, outputs are checked there too
  task automatic apply(input int c, input int cv, input int sl, input int sv,
                       input int can, input int rs, input int va, input int ca);
    bus.in         = c[1:0];
    bus.coin_valid = cv[0];
    bus.sel        = sl[0];
    bus.sel_valid  = sv[0];
    bus.cancel     = can[0];
    bus.restock    = rs[0];
    bus.vend_ack   = va[0];
    bus.change_ack = ca[0];
    model_step(c, cv, sl, sv, can, rs, va, ca);
    @(posedge clk);
    #1;
    bus.in = 2'b00; bus.coin_valid = 0; bus.sel = 0; bus.sel_valid = 0;
    bus.cancel = 0; bus.restock = 0; bus.vend_ack = 0; bus.change_ack = 0;
    check_all();
  endtask

  task automatic coin(input int c);   apply(c, 1, 0, 0, 0, 0, 0, 0); endtask
  task automatic pick(input int s);   apply(0, 0, s, 1, 0, 0, 0, 0); endtask
  task automatic do_cancel();         apply(0, 0, 0, 0, 1, 0, 0, 0); endtask
  task automatic do_restock();        apply(0, 0, 0, 0, 0, 1, 0, 0); endtask
  task automatic vack();              apply(0, 0, 0, 0, 0, 0, 1, 0); endtask
  task automatic cack();              apply(0, 0, 0, 0, 0, 0, 0, 1); endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && (m_vend || m_change); i++) begin
      if (m_vend) vack();
      else cack();
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    bus.in = 2'b00; bus.coin_valid = 0; bus.sel = 0; bus.sel_valid = 0;
    bus.cancel = 0; bus.restock = 0; bus.vend_ack = 0; bus.change_ack = 0;
    model_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all();

    // 10+10, buy A, dispense, no change
    coin(2); coin(2); pick(0); idle(2); vack();
    chk("stock_a_after_first_sale", 32'(bus.stock_a), 32'(STOCK_INIT - 1));
    // 10+10+5, buy B, one 10 rs coin back
    coin(2); coin(2); coin(1); pick(1); vack(); idle(1); cack();
    // fill to 30, fourth 10 refused; bad coin code refused
    coin(2); coin(2); coin(2); coin(2); coin(3); coin(1); coin(1);
    do_cancel(); drain();
    // 5 then A: short credit, then cancel returns one 5
    coin(1); pick(0); do_cancel(); idle(1); cack();
    // coin and selection together: coin wins; cancel and coin together: coin refused
    apply(2, 1, 1, 1, 0, 0, 0, 0);
    apply(1, 1, 0, 0, 1, 0, 0, 0);
    drain();
    // empty product A, then sold out, then restock in IDLE
    for (int k = 0; k < STOCK_INIT + 1 && m_stock[0] > 0; k++) begin
      coin(2); coin(2); pick(0); vack();
    end
    coin(2); coin(2); pick(0);
    apply(0, 0, 0, 0, 0, 1, 0, 0);  // restock in COLLECT is ignored
    do_cancel(); drain();
    do_restock();
    // timeout refund
    coin(2); idle(TIMEOUT + 2); drain();
    // coins during handshakes refused, acks outside their handshake ignored
    coin(2); coin(2); coin(2); pick(1);
    coin(2); cack(); vack(); coin(1); vack(); drain();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      apply(int'($urandom_range(1, 3)),
            ($urandom_range(0, 99) < 30) ? 1 : 0,
            int'($urandom_range(0, 1)),
            ($urandom_range(0, 99) < 25) ? 1 : 0,
            ($urandom_range(0, 99) < 3) ? 1 : 0,
            ($urandom_range(0, 99) < 4) ? 1 : 0,
            ($urandom_range(0, 99) < 35) ? 1 : 0,
            ($urandom_range(0, 99) < 40) ? 1 : 0);
    end
    drain();

    // asynchronous reset while vend_req is high
    coin(2); coin(2); pick(1); idle(1);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all();
    coin(1); idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
